// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   div_state_e : divide sequencer state (RUN / DIV_WAIT)
//   REG_ZERO    : register $0, never a real hazard source
//   NOP_INSTR   : bubble / NOP encoding loaded on a flush
//   sat_inc     : 32-bit saturating increment
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } div_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'b0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_div_sequencer.sv
// Multi-cycle DIVU sequencer: issues the start pulse, holds busy for
// DIV_CYCLES-1 cycles after issue, and pulses done on the final cycle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   ex_is_div   : DIVU issuing from EX this cycle
//   div_start   : one-cycle start pulse to the divider
//   div_busy    : divide in flight
//   div_done    : one-cycle pulse on the final divide cycle
//   div_wait    : sequencer is in DIV_WAIT (HI/LO not yet valid)
module div_sequencer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_is_div,
  output logic div_start,
  output logic div_busy,
  output logic div_done,
  output logic div_wait
);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_start = 1'b0;
    div_busy  = 1'b0;
    div_done  = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (ex_is_div) begin
            div_start = 1'b1;
            state_nxt = DIV_WAIT;
            cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_WAIT: begin
          // ex_is_div cannot legally arrive here (ID DIVU is stalled), so it is ignored.
          div_busy = 1'b1;
          cnt_nxt  = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            div_done  = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign div_wait = (state == DIV_WAIT);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS-Lite core.
// Drives PC / IF/ID enables and IF/ID, ID/EX flushes from load-use and
// HI/LO-after-divide hazards and branch redirects; sequences DIVU and
// keeps a saturating stall-cycle counter.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt : ID source registers
//   id_reads_hilo, id_is_div : ID instruction needs HI/LO / is DIVU
//   ex_memread, ex_rt        : EX load and its destination
//   ex_is_div                : DIVU issuing from EX
//   branch_taken             : redirect resolved in EX
//   en_pc, en_ifid           : register enables
//   flush_ifid, flush_idex   : NOP / bubble loads
//   div_start/busy/done      : divider handshake
//   stall_cnt                : saturating stall-cycle count
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_reads_hilo,
  input  logic        id_is_div,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_is_div,
  input  logic        branch_taken,
  output logic        en_pc,
  output logic        en_ifid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        div_start,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] stall_cnt
);

  logic        div_wait;
  logic        lu_hz, div_hz, stall;
  logic [31:0] stall_q;

  div_sequencer #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_seq (
    .clk       (clk),
    .rst       (rst),
    .ex_is_div (ex_is_div),
    .div_start (div_start),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_wait  (div_wait)
  );

  assign lu_hz  = ex_memread && (ex_rt != REG_ZERO) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign div_hz = div_wait && (id_reads_hilo || id_is_div);
  // A taken branch squashes the ID instruction, so its hazard never stalls.
  assign stall  = (lu_hz || div_hz) && !branch_taken;

  always_comb begin
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (rst) begin
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (stall) begin
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int unsigned DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_reads_hilo, id_is_div;
  logic        ex_memread, ex_is_div, branch_taken;
  logic        en_pc, en_ifid, flush_ifid, flush_idex;
  logic        div_start, div_busy, div_done;
  logic [31:0] stall_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: remaining divide cycles, expected stall count.
  int unsigned     m_div_left = 0;
  longint unsigned m_cnt      = 0;
  bit              m_known    = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_reads_hilo (id_reads_hilo),
    .id_is_div     (id_is_div),
    .ex_memread    (ex_memread),
    .ex_rt         (ex_rt),
    .ex_is_div     (ex_is_div),
    .branch_taken  (branch_taken),
    .en_pc         (en_pc),
    .en_ifid       (en_ifid),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .div_start     (div_start),
    .div_busy      (div_busy),
    .div_done      (div_done),
    .stall_cnt     (stall_cnt)
  );

  wire [6:0] ctrl = {en_pc, en_ifid, flush_ifid, flush_idex, div_start, div_busy, div_done};

  // One cycle: drive at negedge, check mid-low-phase, advance model at posedge.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses_rt, input logic hilo, input logic isdiv,
                      input logic memrd, input logic [4:0] xrt, input logic xdiv,
                      input logic br, input string tag);
    logic [6:0] exp;
    bit lu, dh, st, busy;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_reads_hilo = hilo;
    id_is_div = isdiv; ex_memread = memrd; ex_rt = xrt; ex_is_div = xdiv; branch_taken = br;
    #1;
    busy = (m_div_left > 0);
    lu   = memrd && (xrt != 0) && ((xrt == rs) || (uses_rt && (xrt == rt)));
    dh   = busy && (hilo || isdiv);
    st   = (lu || dh) && !br && !r;
    if (r)       exp = 7'b0011_000;
    else begin
      if (br)      exp[6:3] = 4'b1111;
      else if (st) exp[6:3] = 4'b0001;
      else         exp[6:3] = 4'b1100;
      exp[2] = !busy && xdiv;
      exp[1] = busy;
      exp[0] = (m_div_left == 1);
    end
    total++;
    assert (ctrl === exp) else begin
      bad++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, ctrl, exp);
    end
    if (m_known) begin
      total++;
      assert (stall_cnt === 32'(m_cnt)) else begin
        bad++;
        $error("FAIL %s stall_cnt observed=%h expected=%h", tag, stall_cnt, 32'(m_cnt));
      end
    end
    @(posedge clk);
    if (r) begin
      m_div_left = 0; m_cnt = 0; m_known = 1'b1;
    end else begin
      if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (busy) m_div_left--;
      else if (xdiv) m_div_left = DIV_CYCLES - 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, tag);
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 0; id_reads_hilo = 0;
    id_is_div = 0; ex_memread = 0; ex_rt = '0; ex_is_div = 0; branch_taken = 0;
    @(negedge clk);
    step(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, "reset0");
    step(1, 5'd5, 5'd5, 1, 1, 1, 1, 5'd5, 1, 0, "reset1");
    idle("post_reset");

    // Load-use on rs, then normal flow with count 1
    step(0, 5'd5, 5'd9, 0, 0, 0, 1, 5'd5, 0, 0, "lu_rs");
    idle("lu_after");
    // Load-use on rt
    step(0, 5'd3, 5'd7, 1, 0, 0, 1, 5'd7, 0, 0, "lu_rt");
    // $0 never hazards; unused rt never hazards
    step(0, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, "zero_reg");
    step(0, 5'd3, 5'd7, 0, 0, 0, 1, 5'd7, 0, 0, "rt_unused");
    // Branch beats load-use
    step(0, 5'd5, 5'd0, 0, 0, 0, 1, 5'd5, 0, 1, "br_vs_lu");
    idle("br_after");

    // Divide with MFHI held in ID; a branch mid-countdown
    step(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 1, 0, "div_issue");
    for (int i = 0; i < 31; i++)
      step(0, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 0, (i == 10), "div_wait_mfhi");
    step(0, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 0, 0, "mfhi_go");

    // Reset in the middle of a divide
    step(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 1, 0, "div2_issue");
    for (int i = 0; i < 10; i++)
      step(0, 5'd1, 5'd2, 0, 0, 1, 0, 5'd0, 0, 0, "div2_wait");
    step(1, 5'd1, 5'd2, 0, 0, 1, 0, 5'd0, 0, 0, "div2_rst");
    for (int i = 0; i < 3; i++)
      step(0, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 0, 0, "div2_aborted");

    // Saturation of the stall counter
    force dut.stall_q = 32'hFFFF_FFFD;
    #1 release dut.stall_q;
    m_cnt = 64'hFFFF_FFFD;
    for (int i = 0; i < 4; i++)
      step(0, 5'd4, 5'd0, 0, 0, 0, 1, 5'd4, 0, 0, "sat");
    idle("sat_hold");

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
